ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
Downstream stage of the PS/2 serial-to-parallel converter; runs on the system clock.
- Takes each 11-bit PS/2 frame, checks start, odd parity and stop bits, and strips the E0 (extended) and F0 (break) prefixes.
- Encrypts the scan-code byte with a 16-bit LFSR keystream and buffers the resulting key events in a small FIFO.
- The FIFO drains to the data-transfer stage over a valid/ready handshake.

Parameters:
DEPTH, 4, output FIFO entries; power of two, 2..16.
SEED, 16'hFFFF, LFSR reset value; must be nonzero.
ENCRYPT, 1, 1 = XOR code with keystream; 0 = pass code through, LFSR still steps.

Ports:
Clk  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-high reset.
frame  input  11  received frame: [10]=start, [9]=d0 … [2]=d7, [1]=parity, [0]=stop.
frame_valid  input  1  single-cycle strobe, synchronous to Clk; frame is stable while it is high.
out_data  output  10  {ext, brk, code[7:0]} event at the FIFO head.
out_valid  output  1  FIFO not empty.
out_ready  input  1  consumer accepts; a pop occurs on any edge with out_valid & out_ready.
err_count  output  8  saturating count of rejected frames.
overflow  output  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset values: out_valid=0, out_data=0, err_count=0, overflow=0, FSM=IDLE, FIFO empty, LFSR=SEED.
- Frame check when frame_valid is sampled:
  - frame is good iff frame[10]==0, frame[0]==1, and ^frame[9:1]==1 (odd parity).
  - Bad frame: err_count increments (saturates at 255), FSM returns to IDLE, nothing is emitted.
- Data byte: code = {frame[2],frame[3],…,frame[9]}, i.e. d7..d0.
- Prefix FSM (good frames only):
  - IDLE: E0 -> EXT; F0 -> BRK; any other code -> emit {0,0,code}.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; other code -> emit {1,0,code}, go to IDLE.
  - BRK: F0 or E0 -> stay in BRK; other code -> emit {0,1,code}, go to IDLE.
  - EXT_BRK: prefixes ignored; other code -> emit {1,1,code}, go to IDLE.
  - Prefix bytes are never emitted.
- Pipeline:
  - Edge k samples frame_valid and registers the decoded event plus a push flag.
  - Edge k+1 writes the event to the FIFO; out_valid is high after edge k+1 (2-cycle latency).
  - frame_valid is accepted on back-to-back cycles.
- LFSR (16-bit Fibonacci):
  - Shift left; new LSB = l[15]^l[13]^l[12]^l[10].
  - Key byte = lfsr[7:0], sampled in the same cycle as the write.
  - Steps exactly once per successful FIFO write; does not step on dropped events.
  - Written code = code ^ key when ENCRYPT=1.
- FIFO:
  - First-word-fall-through; out_data is the head entry, 0 when empty.
  - Push and pop on the same edge: both occur, so a write into a full FIFO succeeds when a pop happens on that edge.
  - Push when full with no pop: event dropped, overflow set, LFSR held.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset asserted mid-operation clears every register asynchronously, including the pipeline and FIFO contents. There is no partial state after deassertion.
- overflow and err_count clear only on Reset.

Decomposition:
- Package ps2_pkg holds:
  - typedef scan_state_t {IDLE, EXT, BRK, EXT_BRK};
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, LFSR_TAPS;
  - typedef key_event_t packed {ext, brk, code[7:0]}.
- One sub-module: ps2_event_fifo (parameter DEPTH; push/pop/full/empty/count; width taken from key_event_t).
- Frame check, prefix FSM and LFSR stay in the top module.

Test Plan:
- Make-code 0x1C: frame=11'h0E1 strobed with out_ready=0 -> out_valid rises 2 cycles later; out_data=10'h0E3 (1C^FF); LFSR becomes 16'hFFFE.
- Break sequence: 11'h03F (F0), then 11'h0E1 -> exactly one event, out_data=10'h1E2 (brk=1, 1C^FE); no event for the F0 frame.
- Extended plus break: 11'h01D (E0), 11'h03F (F0), 11'h0E1 -> single event with ext=1, brk=1, code=1C^FF (10'h3E3 from reset).
- Bad parity: 11'h0E3 -> err_count=1, no out_valid; a later 11'h0E1 decodes normally. Start bit=1 also counts as an error.
- Overflow: DEPTH=4, out_ready=0, five good 0x1C frames -> 4 entries, overflow=1, LFSR has stepped 4 times. Then a push with a simultaneous pop on a full FIFO -> count stays at 4 and the event is accepted.
- Reset mid-stream: assert Reset with 2 entries queued and the FSM in BRK -> out_valid=0, err_count=0, LFSR=SEED; after release, 11'h0E1 yields 10'h0E3.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 scan-code decoder.
// Frames arrive as {start, d0..d7, parity, stop}; key events carry ext/brk flags plus the code.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } scan_state_t;

    localparam logic [7:0]  PS2_EXT   = 8'hE0;
    localparam logic [7:0]  PS2_BRK   = 8'hF0;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // bits 15, 13, 12, 10

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    // Data bits are sent LSB first, so d0 sits at frame[9].
    function automatic logic [7:0] frame_code(input logic [10:0] f);
        logic [7:0] c;
        for (int i = 0; i < 8; i++) begin
            c[i] = f[9-i];
        end
        return c;
    endfunction

    function automatic logic frame_good(input logic [10:0] f);
        return !f[10] && f[0] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key events; a push into a full FIFO succeeds
// only when a pop happens on the same edge.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  key_event_t               data_i,
    input  logic                     pop_i,
    output key_event_t               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    key_event_t          mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the storage array is reset too, so no stale event survives a mid-stream reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Checks PS/2 frames, folds E0/F0 prefixes into flags, encrypts the code with an
// LFSR keystream and queues the resulting key events for a valid/ready consumer.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter bit          ENCRYPT = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [10:0] frame,
    input  logic        frame_valid,
    output logic [9:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  err_count,
    output logic        overflow
);

    scan_state_t          state_q;
    key_event_t           event_q;
    logic                 push_q;
    logic [7:0]           err_q;
    logic                 ovf_q;
    logic [15:0]          lfsr_q;

    logic [7:0]           code;
    logic                 good;
    key_event_t           wr_event;
    key_event_t           fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 pop;
    logic                 wr_ok;

    assign code = frame_code(frame);
    assign good = frame_good(frame);

    // Stage 1: frame check and prefix FSM, registering at most one event per strobe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            event_q <= '0;
            push_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
            push_q <= 1'b0;
            if (frame_valid) begin
                if (!good) begin
                    state_q <= IDLE;
                    if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            if (code == PS2_EXT) begin
                                state_q <= EXT;
                            end else if (code == PS2_BRK) begin
                                state_q <= BRK;
                            end else begin
                                event_q <= '{ext: 1'b0, brk: 1'b0, code: code};
                                push_q  <= 1'b1;
                            end
                        end
                        EXT: begin
                            if (code == PS2_BRK) begin
                                state_q <= EXT_BRK;
                            end else if (code != PS2_EXT) begin
                                event_q <= '{ext: 1'b1, brk: 1'b0, code: code};
                                push_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        BRK: begin
                            if (code != PS2_BRK && code != PS2_EXT) begin
                                event_q <= '{ext: 1'b0, brk: 1'b1, code: code};
                                push_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        EXT_BRK: begin
                            if (code != PS2_BRK && code != PS2_EXT) begin
                                event_q <= '{ext: 1'b1, brk: 1'b1, code: code};
                                push_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Stage 2: encrypt with the current key byte and write; the LFSR advances only on accepted writes.
    assign pop   = out_valid & out_ready;
    assign wr_ok = push_q & (~fifo_full | pop);

    always_comb begin
        // NOTE: default first so no path through this block leaves wr_event unassigned (no latch).
        wr_event      = event_q;
        wr_event.code = event_q.code ^ (ENCRYPT ? lfsr_q[7:0] : 8'h00);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= SEED;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                lfsr_q <= lfsr_next(lfsr_q);
            end
            if (push_q && !wr_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push_q),
        .data_i  (wr_event),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = (fifo_count != '0) ? fifo_head : '0;
    assign err_count = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: plain events are queued when frames are
// driven, then encrypted with a reference keystream and compared as the FIFO drains.
module tb_ps2_scan_decoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [10:0] frame;
    logic        frame_valid;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  err_count;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    int          pops_seen = 0;
    logic [9:0]  exp_q[$];
    logic [15:0] lfsr_m;

    ps2_scan_decoder #(
        .DEPTH   (4),
        .SEED    (16'hFFFF),
        .ENCRYPT (1'b1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame       (frame),
        .frame_valid (frame_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_count   (err_count),
        .overflow    (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] c);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9-i] = c[i];
        f[1] = ~(^c);
        f[0] = 1'b1;
        return f;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [10:0] f);
        frame       = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        frame       = '0;
    endtask

    task automatic send_ev(input logic [10:0] f, input logic [9:0] plain);
        exp_q.push_back(plain);
        send(f);
    endtask

    task automatic do_reset();
        #3;
        Reset = 1'b1;
        #1;
        exp_q.delete();
        lfsr_m = 16'hFFFF;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_in_time", n < 200, 1);
        out_ready = 1'b0;
    endtask

    // Consumer side: a pop happens on the next rising edge whenever valid & ready here.
    always @(negedge Clk) begin
        if (!Reset && out_valid && out_ready) begin
            logic [9:0] plain;
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                plain = exp_q.pop_front();
                check("event", out_data, {plain[9:8], plain[7:0] ^ lfsr_m[7:0]});
                lfsr_m = ref_step(lfsr_m);
            end
            pops_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int pops_before;
        Reset       = 1'b1;
        frame       = '0;
        frame_valid = 1'b0;
        out_ready   = 1'b0;
        lfsr_m      = 16'hFFFF;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 10'h000);
        check("rst_err_count", err_count, 0);
        check("rst_overflow", overflow, 0);
        Reset = 1'b0;
        tick();

        // Make code 0x1C: two-cycle latency, first key byte FF.
        check("mk_frame_1c", mk(8'h1C), 11'h0E1);
        send_ev(11'h0E1, 10'h01C);
        check("lat_not_yet", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("make_data", out_data, 10'h0E3);
        drain();

        // Break prefix then 0x1C; key byte is now FE.
        send(11'h03F);
        send_ev(11'h0E1, 10'h11C);
        tick();
        check("brk_data", out_data, 10'h1E2);
        drain();

        // Extended + break from reset.
        do_reset();
        send(11'h01D);
        send(11'h03F);
        send_ev(11'h0E1, 10'h31C);
        tick();
        check("extbrk_data", out_data, 10'h3E3);
        drain();

        // Extended only, with a repeated E0, then a break with a stray E0.
        send(mk(8'hE0));
        send(mk(8'hE0));
        send_ev(mk(8'h75), 10'h275);
        send(mk(8'hF0));
        send(mk(8'hE0));
        send_ev(mk(8'h5A), 10'h15A);
        drain();

        // Bad frames: parity, start and stop errors; a bad frame also cancels a pending break.
        do_reset();
        send(11'h0E3);
        tick();
        check("err_parity", err_count, 1);
        check("err_no_event", out_valid, 0);
        send(11'h4E1);
        tick();
        check("err_start", err_count, 2);
        send(11'h0E0);
        tick();
        check("err_stop", err_count, 3);
        send(mk(8'hF0));
        send(11'h0E3);
        send_ev(11'h0E1, 10'h01C);
        tick();
        check("after_err_data", out_data, 10'h0E3);
        drain();

        // Error counter saturation.
        for (int i = 0; i < 256; i++) send(11'h4E1);
        tick();
        check("err_saturate", err_count, 8'hFF);

        // Overflow: five back-to-back frames into a 4-entry FIFO.
        do_reset();
        for (int i = 0; i < 4; i++) send_ev(11'h0E1, 10'h01C);
        send(11'h0E1);
        tick();
        check("ovf_set", overflow, 1);
        check("ovf_head", out_data, 10'h0E3);
        pops_before = pops_seen;
        exp_q.push_back(10'h029);
        frame = mk(8'h29);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ovf_sticky", overflow, 1);
        check("full_after_swap", pops_seen - pops_before, 1);
        drain();
        check("ovf_total_pops", pops_seen - pops_before, 5);
        check("ovf_after_drain", overflow, 1);

        // Reset mid-stream with entries queued, an error counted and the FSM in BRK.
        do_reset();
        send(11'h0E3);
        send(11'h0E1);
        send(mk(8'h32));
        send(11'h03F);
        tick();
        tick();
        check("pre_rst_valid", out_valid, 1);
        #3;
        Reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 10'h000);
        check("mid_rst_err", err_count, 0);
        exp_q.delete();
        lfsr_m = 16'hFFFF;
        tick();
        Reset = 1'b0;
        send_ev(11'h0E1, 10'h01C);
        tick();
        check("post_rst_data", out_data, 10'h0E3);
        drain();
        check("sb_empty_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
